// File: rtl/divider_scheduler_pkg.sv
// Shared definitions for the divider scheduler: FSM encoding and divisor limits.
package divider_scheduler_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/divider_scheduler_if.sv
// Request/grant bus between requesters and the divider scheduler.
interface divider_scheduler_if #(
  parameter int N = 8,
  parameter int R = 4
) ();

  logic [R-1:0]   req;
  logic [R*N-1:0] req_divisor;
  logic [R-1:0]   grant;
  logic [N-1:0]   divisor_out;
  logic           clock_out;
  logic           period_tick;
  logic           bad_div;

  modport master (
    output req, req_divisor,
    input  grant, divisor_out, clock_out, period_tick, bad_div
  );

  modport slave (
    input  req, req_divisor,
    output grant, divisor_out, clock_out, period_tick, bad_div
  );

endinterface

// File: rtl/divider_scheduler_arbiter.sv
// Round-robin arbiter: priority starts at the bit after the last advanced winner.
module rr_arbiter
  import divider_scheduler_pkg::*;
#(
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [R-1:0] req,
  input  logic         advance,
  output logic [R-1:0] grant,
  output logic         valid
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic          found;

  // pick the first requester at or after ptr, wrapping around
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    next_ptr = ptr;
    for (int k = 0; k < R; k++) begin
      if (!found && req[(int'(ptr) + k) % R]) begin
        grant[(int'(ptr) + k) % R] = 1'b1;
        next_ptr                   = PW'((int'(ptr) + k + 1) % R);
        found                      = 1'b1;
      end else begin
        found = found;
      end
    end
    valid = |req;
  end

  // pointer moves past the winner only when the scheduler acts on it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// Time-shares one programmable clock divider among R requesters, switching owners only on period boundaries.
module divider_scheduler
  import divider_scheduler_pkg::*;
#(
  parameter int N     = 8,
  parameter int R     = 4,
  parameter int SLICE = 4
) (
  input  logic                clock_in,
  input  logic                reset_n,
  divider_scheduler_if.slave  bus
);

  localparam int SW = $clog2(SLICE + 1);

  state_t         state, next_state;
  logic [R-1:0]   owner, next_owner;
  logic [N-1:0]   divisor, next_divisor;
  logic [N-1:0]   counter, next_counter;
  logic [SW-1:0]  slice_cnt, next_slice;
  logic           clk_div, tick, bad, next_bad;

  logic [R-1:0]   arb_req, win;
  logic           win_any;
  logic [N-1:0]   win_div;
  logic           win_ok, boundary, others, owner_req, release_owner;

  rr_arbiter #(.R(R)) u_arb (
    .clk     (clock_in),
    .rst_n   (reset_n),
    .req     (arb_req),
    .advance (win_any),
    .grant   (win),
    .valid   (win_any)
  );

  // release decision; while running, arbitration only sees the other requesters at a releasing boundary
  always_comb begin
    boundary      = (state == RUN) && (counter == divisor - N'(1));
    others        = |(bus.req & ~owner);
    owner_req     = |(bus.req & owner);
    release_owner = boundary && (!owner_req || (others && (slice_cnt >= SW'(SLICE - 1))));
    if (state == IDLE) begin
      arb_req = bus.req;
    end else if (release_owner) begin
      arb_req = bus.req & ~owner;
    end else begin
      arb_req = '0;
    end
    win_div = '0;
    for (int i = 0; i < R; i++) begin
      if (win[i]) begin
        win_div = bus.req_divisor[i*N +: N];
      end else begin
        win_div = win_div;
      end
    end
    win_ok = (win_div >= N'(MIN_DIV));
  end

  // next-state and datapath update
  always_comb begin
    next_state   = state;
    next_owner   = owner;
    next_divisor = divisor;
    next_counter = counter;
    next_slice   = slice_cnt;
    next_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (win_any && win_ok) begin
          next_state   = RUN;
          next_owner   = win;
          next_divisor = win_div;
          next_counter = '0;
          next_slice   = '0;
        end else begin
          next_bad = win_any;
        end
      end
      RUN: begin
        if (!boundary) begin
          next_counter = counter + N'(1);
        end else if (!release_owner) begin
          next_counter = '0;
          next_slice   = (slice_cnt == SW'(SLICE)) ? slice_cnt : slice_cnt + SW'(1);
        end else if (win_any && win_ok) begin
          next_owner   = win;
          next_divisor = win_div;
          next_counter = '0;
          next_slice   = '0;
        end else begin
          next_state   = IDLE;
          next_owner   = '0;
          next_divisor = '0;
          next_counter = '0;
          next_slice   = '0;
          next_bad     = win_any;
        end
      end
      default: begin
        next_state   = IDLE;
        next_owner   = '0;
        next_divisor = '0;
        next_counter = '0;
        next_slice   = '0;
      end
    endcase
  end

  // state and registered outputs; clock_out/period_tick track the counter value they are loaded with
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      divisor   <= '0;
      counter   <= '0;
      slice_cnt <= '0;
      clk_div   <= 1'b0;
      tick      <= 1'b0;
      bad       <= 1'b0;
    end else begin
      state     <= next_state;
      owner     <= next_owner;
      divisor   <= next_divisor;
      counter   <= next_counter;
      slice_cnt <= next_slice;
      clk_div   <= (next_state == RUN) && (next_counter < (next_divisor >> 1));
      tick      <= (next_state == RUN) && (next_counter == next_divisor - N'(1));
      bad       <= next_bad;
    end
  end

  assign bus.grant       = owner;
  assign bus.divisor_out = divisor;
  assign bus.clock_out   = clk_div;
  assign bus.period_tick = tick;
  assign bus.bad_div     = bad;

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler with hand-computed expectations.
module tb_divider_scheduler;

  localparam int N     = 8;
  localparam int R     = 4;
  localparam int SLICE = 4;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  int   vectors  = 0;
  int   miscompares = 0;

  always #5 clock_in = ~clock_in;

  divider_scheduler_if #(.N(N), .R(R)) bus ();

  divider_scheduler #(.N(N), .R(R), .SLICE(SLICE)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_div(input int i, input logic [N-1:0] d);
    bus.req_divisor[i*N +: N] = d;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check_val({tag, "_div"},   32'(bus.divisor_out), 32'h0);
    check_val({tag, "_clk"},   32'(bus.clock_out), 32'h0);
    check_val({tag, "_tick"},  32'(bus.period_tick), 32'h0);
  endtask

  initial begin
    logic [R-1:0] eg;
    logic [N-1:0] ed;
    logic         et;

    bus.req         = '0;
    bus.req_divisor = '0;
    #12;
    check_idle("reset");
    check_val("reset_bad", 32'(bus.bad_div), 32'h0);

    // single owner, divisor 4, held well past SLICE periods
    reset_n = 1'b1;
    set_div(0, 8'd4);
    bus.req = 4'b0001;
    step();
    check_val("d4_div", 32'(bus.divisor_out), 32'd4);
    for (int j = 0; j < 24; j++) begin
      if (j > 0) step();
      check_val("d4_grant", 32'(bus.grant), 32'h1);
      check_val("d4_clk",   32'(bus.clock_out), ((j % 4) < 2) ? 32'h1 : 32'h0);
      check_val("d4_tick",  32'(bus.period_tick), ((j % 4) == 3) ? 32'h1 : 32'h0);
    end
    bus.req = '0;
    step();
    check_idle("d4_release");

    // owner drops at counter 2 of divisor 7; period must finish first
    set_div(1, 8'd7);
    bus.req = 4'b0010;
    step();
    check_val("d7_grant", 32'(bus.grant), 32'h2);
    step();
    step();
    check_val("d7_clk_c2", 32'(bus.clock_out), 32'h1);
    bus.req = '0;
    for (int c = 3; c < 7; c++) begin
      step();
      check_val("d7_hold_grant", 32'(bus.grant), 32'h2);
      check_val("d7_clk", 32'(bus.clock_out), 32'h0);
      check_val("d7_tick", 32'(bus.period_tick), (c == 6) ? 32'h1 : 32'h0);
    end
    step();
    check_idle("d7_release");

    // bad divisor on req[1], then req[3] with a good one
    set_div(1, 8'd1);
    bus.req = 4'b0010;
    step();
    check_val("bad_pulse", 32'(bus.bad_div), 32'h1);
    check_val("bad_grant", 32'(bus.grant), 32'h0);
    set_div(3, 8'd8);
    bus.req = 4'b1010;
    step();
    check_val("bad_clear", 32'(bus.bad_div), 32'h0);
    check_val("d8_grant", 32'(bus.grant), 32'h8);
    check_val("d8_div", 32'(bus.divisor_out), 32'd8);

    // asynchronous reset at counter 3 of divisor 8
    bus.req = 4'b1000;
    step();
    step();
    step();
    check_val("d8_clk_c3", 32'(bus.clock_out), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    check_val("async_rst_bad", 32'(bus.bad_div), 32'h0);
    bus.req = 4'b0100;
    set_div(2, 8'd5);
    #1;
    reset_n = 1'b1;
    step();
    check_val("post_rst_grant", 32'(bus.grant), 32'h4);
    check_val("post_rst_div", 32'(bus.divisor_out), 32'd5);

    // two requesters sharing by SLICE periods: div 6 on req[0], div 10 on req[2]
    #2;
    reset_n = 1'b0;
    #1;
    set_div(0, 8'd6);
    set_div(2, 8'd10);
    bus.req = 4'b0101;
    #1;
    reset_n = 1'b1;
    step();
    for (int j = 0; j < 70; j++) begin
      if (j > 0) step();
      if (j < 24) begin
        eg = 4'b0001; ed = 8'd6;  et = ((j % 6) == 5);
      end else if (j < 64) begin
        eg = 4'b0100; ed = 8'd10; et = (((j - 24) % 10) == 9);
      end else begin
        eg = 4'b0001; ed = 8'd6;  et = (((j - 64) % 6) == 5);
      end
      check_val("share_grant", 32'(bus.grant), 32'(eg));
      check_val("share_div",   32'(bus.divisor_out), 32'(ed));
      check_val("share_tick",  32'(bus.period_tick), 32'(et));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
